// File: rtl/branch_pred_pkg.sv
// Shared constants for the branch trace sequencer: FSM state encodings and default widths.
package branch_pred_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_WAIT_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_PRED = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_COMPLETE  = 3'd5;
    localparam logic [2:0] ST_GAP       = 3'd6;

endpackage

// File: rtl/branch_trace_sequencer_fifo.sv
// Synchronous trace buffer with combinational head read; pop takes effect on the same clock edge.
// push_rdy is registered from the post-update fill level, so a full buffer refuses pushes until one cycle after a pop.
module trace_fifo
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DEFAULT_ADDR_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rdy_q, rdy_d;
    logic             push_fire, pop_fire, empty, full_d;

    assign empty     = (count_q == '0);
    assign push_fire = push_vld & rdy_q;
    assign pop_fire  = pop_rdy & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
        rdy_d  = ~full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_dat;
    end

    assign push_rdy = rdy_q;
    assign pop_vld  = ~empty;
    assign pop_dat  = mem_q[rd_ptr_q];

endmodule

// File: rtl/branch_trace_sequencer.sv
// Feeds buffered (addr, dir) trace entries to the perceptron predictor one at a time and tallies mispredictions.
// Push into an empty buffer raises bp_new_data_avail 2 cycles later; trace_ready drops (registered) when the buffer fills.
module branch_trace_sequencer
    import branch_pred_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_valid,
    output logic                  trace_ready,
    input  logic [ADDR_WIDTH-1:0] trace_addr,
    input  logic                  trace_dir,
    input  logic                  stats_clear,
    input  logic                  bp_mem_reset_done,
    input  logic                  bp_pred_ready,
    input  logic                  bp_prediction,
    input  logic                  bp_training_done,
    output logic [ADDR_WIDTH-1:0] bp_inst_addr,
    output logic                  bp_new_data_avail,
    output logic                  bp_dir_gt,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  total_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt,
    output logic                  timeout_flag
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic                  init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  dir_q, dir_d;
    logic                  pred_q, pred_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [CNT_WIDTH-1:0]  mispred_q, mispred_d;
    logic                  tmo_flag_q, tmo_flag_d;
    logic                  nda_q, nda_d;
    logic                  busy_q, busy_d;

    logic                  fifo_vld, fifo_pop, tmo_expired;
    logic [ADDR_WIDTH:0]   fifo_dat;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (trace_valid),
        .push_rdy (trace_ready),
        .push_dat ({trace_addr, trace_dir}),
        .pop_vld  (fifo_vld),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_dat)
    );

    assign tmo_expired = (tmo_q == '0);

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q | bp_mem_reset_done;
        addr_d      = addr_q;
        dir_d       = dir_q;
        pred_d      = pred_q;
        tmo_d       = tmo_q;
        total_d     = total_q;
        mispred_d   = mispred_q;
        tmo_flag_d  = tmo_flag_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_WAIT_INIT: begin
                if (init_done_d) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifo_vld) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_dat[ADDR_WIDTH:1];
                    dir_d    = fifo_dat[0];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Loaded one short so the wait states span TIMEOUT_CYCLES cycles including the zero count.
                tmo_d   = TW'(TIMEOUT_CYCLES - 1);
                state_d = ST_WAIT_PRED;
            end
            ST_WAIT_PRED: begin
                if (!tmo_expired) tmo_d = tmo_q - TW'(1);
                if (bp_pred_ready) begin
                    pred_d  = bp_prediction;
                    state_d = bp_training_done ? ST_COMPLETE : ST_WAIT_DONE;
                end else if (tmo_expired) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!tmo_expired) tmo_d = tmo_q - TW'(1);
                if (bp_training_done) begin
                    state_d = ST_COMPLETE;
                end else if (tmo_expired) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_COMPLETE: begin
                if (total_q != '1) total_d = total_q + CNT_WIDTH'(1);
                if ((pred_q != dir_q) && (mispred_q != '1)) mispred_d = mispred_q + CNT_WIDTH'(1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_WAIT_INIT;
            end
        endcase

        if (stats_clear) begin
            total_d    = '0;
            mispred_d  = '0;
            tmo_flag_d = 1'b0;
        end
    end

    // Request level and busy are registered from the next state so the predictor sees clean edges.
    assign nda_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT_PRED) || (state_d == ST_WAIT_DONE);
    assign busy_d = nda_d || (state_d == ST_COMPLETE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_INIT;
            init_done_q <= 1'b0;
            addr_q      <= '0;
            dir_q       <= 1'b0;
            pred_q      <= 1'b0;
            tmo_q       <= '0;
            total_q     <= '0;
            mispred_q   <= '0;
            tmo_flag_q  <= 1'b0;
            nda_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            dir_q       <= dir_d;
            pred_q      <= pred_d;
            tmo_q       <= tmo_d;
            total_q     <= total_d;
            mispred_q   <= mispred_d;
            tmo_flag_q  <= tmo_flag_d;
            nda_q       <= nda_d;
            busy_q      <= busy_d;
        end
    end

    assign bp_inst_addr      = addr_q;
    assign bp_dir_gt         = dir_q;
    assign bp_new_data_avail = nda_q;
    assign busy              = busy_q;
    assign total_cnt         = total_q;
    assign mispred_cnt       = mispred_q;
    assign timeout_flag      = tmo_flag_q;

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// Directed + randomized bench: a predictor responder and an in-order queue model predict issues and statistics.
module tb_branch_trace_sequencer;

    logic        clk;
    logic        rst_n;
    logic        trace_valid;
    logic        trace_ready;
    logic [7:0]  trace_addr;
    logic        trace_dir;
    logic        stats_clear;
    logic        bp_mem_reset_done;
    logic        bp_pred_ready;
    logic        bp_prediction;
    logic        bp_training_done;
    logic [7:0]  bp_inst_addr;
    logic        bp_new_data_avail;
    logic        bp_dir_gt;
    logic        busy;
    logic [15:0] total_cnt;
    logic [15:0] mispred_cnt;
    logic        timeout_flag;

    branch_trace_sequencer #(
        .FIFO_DEPTH     (8),
        .ADDR_WIDTH     (8),
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_addr        (trace_addr),
        .trace_dir         (trace_dir),
        .stats_clear       (stats_clear),
        .bp_mem_reset_done (bp_mem_reset_done),
        .bp_pred_ready     (bp_pred_ready),
        .bp_prediction     (bp_prediction),
        .bp_training_done  (bp_training_done),
        .bp_inst_addr      (bp_inst_addr),
        .bp_new_data_avail (bp_new_data_avail),
        .bp_dir_gt         (bp_dir_gt),
        .busy              (busy),
        .total_cnt         (total_cnt),
        .mispred_cnt       (mispred_cnt),
        .timeout_flag      (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [8:0] exp_q[$];
    int         exp_total   = 0;
    int         exp_mispred = 0;
    bit         exp_flag    = 0;

    // Predictor responder configuration and observation
    int   pred_lat = 1, train_lat = 1, pred_sel = 2;
    bit   rand_lat = 0, stall_once = 0;
    int   phase = 0, timer = 0, high_len = 0, last_high_len = 0;
    int   issued = 0, aborts = 0, stall_cycles = 0;
    logic [7:0] cur_a;
    logic cur_d, cur_p, nda_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_txn();
        last_high_len = high_len;
        if (exp_total < 65535) exp_total++;
        if (cur_p != cur_d && exp_mispred < 65535) exp_mispred++;
        phase = 4;
    endtask

    initial begin : responder
        logic [8:0] e;
        bp_pred_ready = 0; bp_prediction = 0; bp_training_done = 0; nda_prev = 0;
        forever begin
            @(negedge clk);
            bp_pred_ready = 0;
            bp_training_done = 0;
            if (!rst_n) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (bp_new_data_avail && !nda_prev) begin
                        check("issue_busy", busy, 1);
                        tests++;
                        assert (exp_q.size() != 0) else begin
                            fails++;
                            $error("FAIL issue_unexpected: addr %0h issued, none expected", bp_inst_addr);
                        end
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("issue_addr", bp_inst_addr, e[8:1]);
                            check("issue_dir", bp_dir_gt, e[0]);
                        end
                        cur_a = bp_inst_addr; cur_d = bp_dir_gt;
                        issued++; high_len = 1;
                        if (rand_lat) begin
                            pred_lat = $urandom_range(0, 3);
                            train_lat = $urandom_range(0, 6);
                        end
                        timer = pred_lat;
                        if (stall_once) begin
                            stall_once = 0; stall_cycles = 0; phase = 3;
                        end else phase = 1;
                    end
                    1, 2: begin
                        check("hold_addr", bp_inst_addr, cur_a);
                        check("hold_dir", bp_dir_gt, cur_d);
                        check("hold_nda", bp_new_data_avail, 1);
                        if (bp_new_data_avail) high_len++;
                        if (phase == 1) begin
                            if (timer == 0) begin
                                cur_p = (pred_sel == 2) ? 1'($urandom_range(0, 1)) : pred_sel[0];
                                bp_pred_ready = 1; bp_prediction = cur_p;
                                if (train_lat == 0) begin
                                    bp_training_done = 1; finish_txn();
                                end else begin
                                    timer = train_lat; phase = 2;
                                end
                            end else timer--;
                        end else begin
                            timer--;
                            if (timer == 0) begin
                                bp_training_done = 1; finish_txn();
                            end
                        end
                    end
                    3: begin
                        stall_cycles++;
                        if (!bp_new_data_avail) begin
                            check("timeout_window", (stall_cycles >= 250 && stall_cycles <= 262), 1);
                            check("timeout_gap_busy", busy, 0);
                            exp_flag = 1; aborts++; phase = 0;
                        end
                    end
                    4: begin
                        check("complete_nda", bp_new_data_avail, 0);
                        check("complete_busy", busy, 1);
                        phase = 5;
                    end
                    5: begin
                        check("gap_nda", bp_new_data_avail, 0);
                        check("gap_busy", busy, 0);
                        phase = 0;
                    end
                    default: phase = 0;
                endcase
            end
            nda_prev = bp_new_data_avail;
        end
    end

    task automatic push(input logic [7:0] a, input logic d, output int waited);
        waited = 0;
        trace_valid = 1; trace_addr = a; trace_dir = d;
        while (!trace_ready && waited < 1000) begin
            @(negedge clk); waited++;
        end
        check("push_ready_bound", waited < 1000, 1);
        @(negedge clk);
        trace_valid = 0;
        exp_q.push_back({a, d});
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || phase != 0 || busy) && g < 3000) begin
            @(negedge clk); g++;
        end
        check("drain_bound", g < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_total"}, total_cnt, exp_total);
        check({tag, "_mispred"}, mispred_cnt, exp_mispred);
        check({tag, "_flag"}, timeout_flag, exp_flag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, trace_ready, 1);
        check({tag, "_nda"}, bp_new_data_avail, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_addr"}, bp_inst_addr, 0);
        check({tag, "_dir"}, bp_dir_gt, 0);
        check({tag, "_total"}, total_cnt, 0);
        check({tag, "_mispred"}, mispred_cnt, 0);
        check({tag, "_flag"}, timeout_flag, 0);
    endtask

    task automatic pulse_init();
        bp_mem_reset_done = 1;
        @(negedge clk);
        bp_mem_reset_done = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int w, base, g, base_issued;
        rst_n = 0; trace_valid = 0; trace_addr = 0; trace_dir = 0;
        stats_clear = 0; bp_mem_reset_done = 0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1;
        @(negedge clk);
        check_reset("post_rst");

        // Entries pushed before predictor init must wait for the init pulse
        pred_lat = 2; train_lat = 1; pred_sel = 2;
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom), w);
        repeat (6) @(negedge clk);
        check("init_wait_nda", bp_new_data_avail, 0);
        check("init_wait_issued", issued, 0);
        bp_mem_reset_done = 1;
        @(negedge clk);
        bp_mem_reset_done = 0;
        check("init_no_early_rise", bp_new_data_avail, 0);
        @(negedge clk);
        check("init_rise", bp_new_data_avail, 1);
        drain();
        check("init_issued3", issued, 3);
        check_stats("t1");

        // Combined pred_ready + training_done, correct prediction
        pred_lat = 0; train_lat = 0; pred_sel = 1;
        base = exp_total;
        push(8'h2C, 1'b1, w);
        drain();
        check("t2_total_inc", total_cnt, base + 1);
        check("t2_high_len", last_high_len, 2);
        check_stats("t2");

        // Late training_done with a misprediction
        pred_lat = 1; train_lat = 20; pred_sel = 1;
        base = exp_mispred;
        push(8'($urandom), 1'b0, w);
        drain();
        check("t3_mispred_inc", mispred_cnt, base + 1);
        check("t3_high_len", last_high_len, 23);
        check_stats("t3");

        // Fill the buffer behind a slow in-flight branch
        pred_lat = 30; train_lat = 5; pred_sel = 2;
        push(8'($urandom), 1'($urandom), w);
        g = 0;
        while (!busy && g < 20) begin @(negedge clk); g++; end
        check("t4_busy", busy, 1);
        base = exp_total;
        for (int i = 0; i < 8; i++) push(8'($urandom), 1'($urandom), w);
        check("t4_full_ready", trace_ready, 0);
        push(8'($urandom), 1'($urandom), w);
        check("t4_ninth_held", w > 10, 1);
        check("t4_first_done", total_cnt, base + 1);
        drain();
        check_stats("t4");

        // Randomized regression with varying predictor latency
        rand_lat = 1; pred_sel = 2;
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom), 1'($urandom), w);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        drain();
        rand_lat = 0;
        check_stats("rand");

        // Unresponsive predictor: abort, then the next entry proceeds
        pred_lat = 1; train_lat = 2; pred_sel = 0;
        base = exp_total;
        stall_once = 1;
        push(8'($urandom), 1'($urandom), w);
        push(8'($urandom), 1'($urandom), w);
        drain();
        check("t5_aborts", aborts, 1);
        check("t5_total_after", total_cnt, base + 1);
        check_stats("t5");
        stats_clear = 1;
        @(negedge clk);
        stats_clear = 0;
        exp_total = 0; exp_mispred = 0; exp_flag = 0;
        check_stats("clear");

        // Reset during WAIT_DONE discards everything
        pred_lat = 0; train_lat = 50; pred_sel = 2;
        push(8'($urandom), 1'($urandom), w);
        g = 0;
        while (phase != 2 && g < 50) begin @(negedge clk); g++; end
        check("t6_in_wait_done", phase, 2);
        push(8'($urandom), 1'($urandom), w);
        push(8'($urandom), 1'($urandom), w);
        rst_n = 0;
        @(negedge clk);
        check_reset("t6_rst");
        exp_q.delete();
        exp_total = 0; exp_mispred = 0; exp_flag = 0;
        rst_n = 1;
        repeat (2) @(negedge clk);
        base_issued = issued;
        pulse_init();
        repeat (10) @(negedge clk);
        check("t6_fifo_empty_issued", issued, base_issued);
        check("t6_fifo_empty_busy", busy, 0);
        pred_lat = 1; train_lat = 1;
        push(8'($urandom), 1'($urandom), w);
        drain();
        check("t6_issued_after", issued, base_issued + 1);
        check_stats("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
